// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bus between the datapath (master) and the data memory controller (slave).
interface dmem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Mem_Write;
    logic              Size;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Data_Write;
    logic              Resp_Ready;
    logic              Resp_Valid;
    logic [DATA_W-1:0] DataM_out;
    logic              Err;

    modport master (
        output Req_Valid, Mem_Write, Size, Addr, Data_Write, Resp_Ready,
        input  Req_Ready, Resp_Valid, DataM_out, Err
    );

    modport slave (
        input  Req_Valid, Mem_Write, Size, Addr, Data_Write, Resp_Ready,
        output Req_Ready, Resp_Valid, DataM_out, Err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: big-endian byte-addressable data memory with request/response handshake and configurable read latency.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range accesses instead of wrapping modulo DEPTH.
module dmem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, next;
    logic [2:0]        cnt;
    logic [7:0]        mem [DEPTH] = '{default: 8'h00};
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] rdata, ld_data, snap_d;
    logic              mis, oob, err, accept, we, snap_e;

    assign idx = IW'(bus.Addr);
    assign mis = bus.Size && ((bus.Addr % ADDR_W'(NB)) != '0);
`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = (32'(bus.Addr) >= 32'(DEPTH)) ||
                 (bus.Size && (32'(bus.Addr) + 32'(NB - 1) >= 32'(DEPTH)));
`else
    assign oob = 1'b0;
`endif
    assign err           = mis || oob;
    assign bus.Req_Ready = rst_n && (state == IDLE);
    assign accept        = bus.Req_Valid && bus.Req_Ready;
    assign we            = accept && bus.Mem_Write && !err;
    assign ld_data       = (bus.Mem_Write || err) ? '0 : rdata;

    // Byte 0 of a word sits in the most significant lane; offsets wrap within the array.
    always_comb begin
        rdata = '0;
        if (bus.Size)
            for (int i = 0; i < NB; i++) rdata[DATA_W-1-8*i -: 8] = mem[idx + IW'(i)];
        else
            rdata[7:0] = mem[idx];
    end

    always_ff @(posedge clk)
        if (we) begin
            if (bus.Size)
                for (int i = 0; i < NB; i++) mem[idx + IW'(i)] <= bus.Data_Write[DATA_W-1-8*i -: 8];
            else
                mem[idx] <= bus.Data_Write[7:0];
        end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? ((bus.Mem_Write || RD_LAT == 1) ? RESP : WAIT) : IDLE;
            WAIT:    next = (cnt == 3'd1) ? RESP : WAIT;
            RESP:    next = bus.Resp_Ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    // Load data is captured at accept so later stores cannot disturb a pending response.
    always_ff @(posedge clk)
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            snap_d         <= '0;
            snap_e         <= 1'b0;
            bus.Resp_Valid <= 1'b0;
            bus.DataM_out  <= '0;
            bus.Err        <= 1'b0;
        end else begin
            state <= next;
            cnt   <= (accept && !bus.Mem_Write) ? 3'(RD_LAT - 1) : (cnt != '0 ? cnt - 3'd1 : cnt);
            if (accept) begin
                snap_d <= ld_data;
                snap_e <= err;
            end
            bus.Resp_Valid <= next == RESP;
            bus.DataM_out  <= next != RESP ? '0 : state == IDLE ? ld_data : state == WAIT ? snap_d : bus.DataM_out;
            bus.Err        <= next != RESP ? 1'b0 : state == IDLE ? err : state == WAIT ? snap_e : bus.Err;
        end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors applied to RD_LAT=1 and RD_LAT=3 instances in lockstep, plus stall and reset sequences.
module tb_dmem_ctrl;
    typedef struct {
        logic        we;
        logic        sz;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    dmem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ia ();
    dmem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ib ();

    dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ia.slave));
    dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input int n, input vec_t v);
        int la, lb;
        logic [15:0] da, db;
        logic ea, eb;
        la = 0; lb = 0; da = '0; db = '0; ea = 1'b0; eb = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_rdy_a", n), 32'(ia.Req_Ready), 1);
        chk($sformatf("v%0d_rdy_b", n), 32'(ib.Req_Ready), 1);
        ia.Req_Valid = 1'b1; ia.Mem_Write = v.we; ia.Size = v.sz; ia.Addr = v.addr; ia.Data_Write = v.wd;
        ib.Req_Valid = 1'b1; ib.Mem_Write = v.we; ib.Size = v.sz; ib.Addr = v.addr; ib.Data_Write = v.wd;
        @(negedge clk);
        ia.Req_Valid = 1'b0; ia.Resp_Ready = 1'b1;
        ib.Req_Valid = 1'b0; ib.Resp_Ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (ia.Resp_Valid && la == 0) begin la = c; da = ia.DataM_out; ea = ia.Err; end
            if (ib.Resp_Valid && lb == 0) begin lb = c; db = ib.DataM_out; eb = ib.Err; end
            if (la != 0 && lb != 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        ia.Resp_Ready = 1'b0;
        ib.Resp_Ready = 1'b0;
        chk($sformatf("v%0d_lat_a", n), 32'(la), 1);
        chk($sformatf("v%0d_lat_b", n), 32'(lb), v.we ? 1 : 3);
        chk($sformatf("v%0d_data_a", n), 32'(da), 32'(v.exp_d));
        chk($sformatf("v%0d_data_b", n), 32'(db), 32'(v.exp_d));
        chk($sformatf("v%0d_err_a", n), 32'(ea), 32'(v.exp_e));
        chk($sformatf("v%0d_err_b", n), 32'(eb), 32'(v.exp_e));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 16'h0010, 16'hABCD, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hABCD, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0011, 16'hFF5A, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hAB5A, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00AB, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h005A, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'h0013, 16'h1234, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 16'h0012, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 16'h0000, 1'b1};
`ifdef DMEM_BOUNDS_CHECK_EN
        vecs[9]  = '{1'b1, 1'b1, 16'h01FE, 16'hBEEF, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 16'h00FE, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h00FE, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0105, 16'h0077, 16'h0000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0};
`else
        vecs[9]  = '{1'b1, 1'b1, 16'h01FE, 16'hBEEF, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h00FE, 16'h0000, 16'h00BE, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h00FE, 16'h0000, 16'hBEEF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0105, 16'h0077, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0077, 1'b0};
`endif
        ia.Req_Valid = 1'b0; ia.Mem_Write = 1'b0; ia.Size = 1'b0; ia.Addr = '0; ia.Data_Write = '0; ia.Resp_Ready = 1'b0;
        ib.Req_Valid = 1'b0; ib.Mem_Write = 1'b0; ib.Size = 1'b0; ib.Addr = '0; ib.Data_Write = '0; ib.Resp_Ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_rdy_a", 32'(ia.Req_Ready), 0);
        chk("rst_rdy_b", 32'(ib.Req_Ready), 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy_a", 32'(ia.Req_Ready), 1);
        chk("post_rst_rv_a", 32'(ia.Resp_Valid), 0);
        chk("post_rst_data_a", 32'(ia.DataM_out), 0);
        chk("post_rst_err_a", 32'(ia.Err), 0);
        chk("post_rst_rv_b", 32'(ib.Resp_Valid), 0);
        chk("post_rst_data_b", 32'(ib.DataM_out), 0);

        for (int i = 0; i < 14; i++) run(i, vecs[i]);

        // Back-pressured load on the RD_LAT=1 instance with a stray request in the stall window.
        @(negedge clk);
        ia.Req_Valid = 1'b1; ia.Mem_Write = 1'b0; ia.Size = 1'b1; ia.Addr = 16'h0010;
        @(negedge clk);
        ia.Req_Valid = 1'b0; ia.Resp_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_rv", i), 32'(ia.Resp_Valid), 1);
            chk($sformatf("stall%0d_data", i), 32'(ia.DataM_out), 32'h0000AB5A);
            chk($sformatf("stall%0d_err", i), 32'(ia.Err), 0);
            chk($sformatf("stall%0d_rdy", i), 32'(ia.Req_Ready), 0);
            if (i == 2) begin
                ia.Req_Valid = 1'b1; ia.Mem_Write = 1'b1; ia.Addr = 16'h0010; ia.Data_Write = 16'h0000;
            end else ia.Req_Valid = 1'b0;
            @(negedge clk);
        end
        ia.Req_Valid = 1'b0;
        ia.Resp_Ready = 1'b1;
        @(negedge clk);
        ia.Resp_Ready = 1'b0;
        chk("stall_exit_rdy", 32'(ia.Req_Ready), 1);
        chk("stall_exit_rv", 32'(ia.Resp_Valid), 0);
        chk("stall_exit_data", 32'(ia.DataM_out), 0);
        run(14, '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hAB5A, 1'b0});

        // Reset one cycle into a RD_LAT=3 load abandons the response.
        @(negedge clk);
        ib.Req_Valid = 1'b1; ib.Mem_Write = 1'b0; ib.Size = 1'b1; ib.Addr = 16'h0010; ib.Resp_Ready = 1'b1;
        @(negedge clk);
        ib.Req_Valid = 1'b0;
        chk("abort_rdy_wait", 32'(ib.Req_Ready), 0);
        chk("abort_rv_wait", 32'(ib.Resp_Valid), 0);
        rst_b_n = 1'b0;
        @(negedge clk);
        chk("abort_rdy_rst", 32'(ib.Req_Ready), 0);
        chk("abort_rv_rst", 32'(ib.Resp_Valid), 0);
        rst_b_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort%0d_rdy", i), 32'(ib.Req_Ready), 1);
            chk($sformatf("abort%0d_rv", i), 32'(ib.Resp_Valid), 0);
        end
        ib.Resp_Ready = 1'b0;
        run(15, '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hAB5A, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
